// File: rtl/demux_pkg.sv
// Shared constants for the 1-to-4 stream demultiplexer: channel select codes
// and per-channel buffer depth.
package demux_pkg;
   localparam int         NUM_CHAN   = 4;
   localparam logic [1:0] SEL_A      = 2'b00;
   localparam logic [1:0] SEL_B      = 2'b01;
   localparam logic [1:0] SEL_C      = 2'b10;
   localparam logic [1:0] SEL_D      = 2'b11;
   localparam logic [1:0] CHAN_DEPTH = 2'd2;
endpackage

// File: rtl/chan_buf.sv
// Two-entry FIFO for one output channel. The head is copied into a dedicated
// output register, so rd_data holds its last value while the buffer is empty.
module chan_buf
   import demux_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   output logic             full,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             valid
);
   logic [WIDTH-1:0] mem_q [2];
   logic [WIDTH-1:0] mem_d [2];
   logic             wr_ptr_q, wr_ptr_d;
   logic             rd_ptr_q, rd_ptr_d;
   logic [1:0]       cnt_q, cnt_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             vld_q, vld_d;
   logic             push, pop;

   always_comb begin
      push     = wr_en && (cnt_q != CHAN_DEPTH);
      pop      = rd_en && vld_q;
      mem_d    = mem_q;
      if (push) mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d = wr_ptr_q ^ push;
      rd_ptr_d = rd_ptr_q ^ pop;
      cnt_d    = cnt_q + {1'b0, push} - {1'b0, pop};
      vld_d    = (cnt_d != 2'd0);
      // Next head comes from the post-update storage so a push into an empty
      // buffer shows up one cycle later; otherwise keep the last value.
      dout_d   = vld_d ? mem_d[rd_ptr_d] : dout_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         cnt_q    <= 2'd0;
         dout_q   <= '0;
         vld_q    <= 1'b0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         dout_q   <= dout_d;
         vld_q    <= vld_d;
      end
   end

   assign full    = (cnt_q == CHAN_DEPTH);
   assign rd_data = dout_q;
   assign valid   = vld_q;
endmodule

// File: rtl/demux1x4_stream.sv
// Valid/ready stream demultiplexer: routes each input beat to one of four
// independently buffered output channels selected by in_sel.
module demux1x4_stream
   import demux_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [1:0]       in_sel,
   output logic [WIDTH-1:0] out_a,
   output logic [WIDTH-1:0] out_b,
   output logic [WIDTH-1:0] out_c,
   output logic [WIDTH-1:0] out_d,
   output logic [3:0]       out_valid,
   input  logic [3:0]       out_ready,
   output logic             busy
);
   logic [NUM_CHAN-1:0]            full;
   logic [NUM_CHAN-1:0]            wr_en;
   logic [NUM_CHAN-1:0][WIDTH-1:0] rd_data;

   // Ready reflects only the addressed channel, so a full channel never
   // stalls traffic headed elsewhere.
   always_comb begin
      in_ready      = !rst && !full[in_sel];
      wr_en         = '0;
      wr_en[in_sel] = in_valid && in_ready;
   end

   for (genvar i = 0; i < NUM_CHAN; i++) begin : g_chan
      chan_buf #(.WIDTH(WIDTH)) u_buf (
         .clk     (clk),
         .rst     (rst),
         .wr_en   (wr_en[i]),
         .wr_data (in_data),
         .full    (full[i]),
         .rd_en   (out_ready[i]),
         .rd_data (rd_data[i]),
         .valid   (out_valid[i])
      );
   end

   assign out_a = rd_data[SEL_A];
   assign out_b = rd_data[SEL_B];
   assign out_c = rd_data[SEL_C];
   assign out_d = rd_data[SEL_D];
   assign busy  = |out_valid;
endmodule

// File: tb/tb_demux1x4_stream.sv
// Bench for demux1x4_stream (WIDTH=8): directed scenarios plus a randomized
// run checked against per-channel queue model.
module tb_demux1x4_stream;
   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic [1:0] in_sel;
   logic [7:0] out_a, out_b, out_c, out_d;
   logic [3:0] out_valid;
   logic [3:0] out_ready;
   logic       busy;

   int tests = 0;
   int fails = 0;

   logic [3:0][7:0] outs;
   assign outs = {out_d, out_c, out_b, out_a};

   demux1x4_stream #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_sel    (in_sel),
      .out_a     (out_a),
      .out_b     (out_b),
      .out_c     (out_c),
      .out_d     (out_d),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_sel = 2'b00; out_ready = 4'h0;
      repeat (2) tick();
      in_valid = 1'b1;
      #1;
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready: got %b exp 0", in_ready); end
      tests++; if (out_valid !== 4'b0000) begin fails++; $display("FAIL reset_out_valid: got %b exp 0000", out_valid); end
      tests++; if (outs !== 32'h0) begin fails++; $display("FAIL reset_outs: got %h exp 0", outs); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b exp 0", busy); end
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      for (int s = 0; s < 4; s++) begin
         in_sel = 2'(s);
         #1;
         tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL post_reset_ready sel%0d: got %b exp 1", s, in_ready); end
      end
      tick();
   endtask

   task automatic test_basic();
      in_sel = 2'b10; in_data = 8'h5A; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tests++; if (out_valid !== 4'b0100) begin fails++; $display("FAIL basic_valid: got %b exp 0100", out_valid); end
      tests++; if (out_c !== 8'h5A) begin fails++; $display("FAIL basic_out_c: got %h exp 5a", out_c); end
      tests++; if (busy !== 1'b1) begin fails++; $display("FAIL basic_busy: got %b exp 1", busy); end
      tests++; if ({out_a, out_b, out_d} !== 24'h0) begin fails++; $display("FAIL basic_others: got %h exp 0", {out_a, out_b, out_d}); end
      out_ready = 4'hF;
      tick();
      out_ready = 4'h0;
      tests++; if (out_valid !== 4'b0000) begin fails++; $display("FAIL basic_drain: got %b exp 0000", out_valid); end
      tests++; if (out_c !== 8'h5A) begin fails++; $display("FAIL basic_hold: got %h exp 5a", out_c); end
   endtask

   task automatic test_back_to_back();
      out_ready = 4'h0; in_sel = 2'b00; in_valid = 1'b1; in_data = 8'h11;
      #1;
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready0: got %b exp 1", in_ready); end
      tick();
      in_data = 8'h22;
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready1: got %b exp 1", in_ready); end
      tick();
      in_data = 8'h33;
      #1;
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL b2b_full: got %b exp 0", in_ready); end
      tick();
      tests++; if (out_a !== 8'h11) begin fails++; $display("FAIL b2b_head: got %h exp 11", out_a); end
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL b2b_held: got %b exp 0", in_ready); end
      out_ready = 4'b0001;
      tick();
      tests++; if (out_a !== 8'h22) begin fails++; $display("FAIL b2b_second: got %h exp 22", out_a); end
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_reopen: got %b exp 1", in_ready); end
      tick();
      in_valid = 1'b0;
      tests++; if (out_a !== 8'h33 || out_valid[0] !== 1'b1) begin fails++; $display("FAIL b2b_third: got %h/%b exp 33/1", out_a, out_valid[0]); end
      tick();
      out_ready = 4'h0;
      tests++; if (out_valid !== 4'b0000) begin fails++; $display("FAIL b2b_empty: got %b exp 0000", out_valid); end
   endtask

   task automatic test_simul();
      in_sel = 2'b01; in_data = 8'h77; in_valid = 1'b1;
      tick();
      in_data = 8'hAB; out_ready = 4'b0010;
      tick();
      in_valid = 1'b0; out_ready = 4'h0;
      tests++; if (out_valid[1] !== 1'b1 || out_b !== 8'hAB) begin fails++; $display("FAIL simul_out_b: got %b/%h exp 1/ab", out_valid[1], out_b); end
      out_ready = 4'b0010;
      tick();
      out_ready = 4'h0;
      tests++; if (out_valid[1] !== 1'b0) begin fails++; $display("FAIL simul_occ1: got %b exp 0", out_valid[1]); end
   endtask

   task automatic test_full_other();
      in_sel = 2'b11; in_valid = 1'b1; in_data = 8'hC1;
      tick();
      in_data = 8'hC2;
      tick();
      #1;
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL other_d_full: got %b exp 0", in_ready); end
      in_sel = 2'b00; in_data = 8'h99;
      #1;
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL other_a_ready: got %b exp 1", in_ready); end
      tick();
      in_valid = 1'b0;
      tests++; if (out_valid !== 4'b1001) begin fails++; $display("FAIL other_valid: got %b exp 1001", out_valid); end
      tests++; if (out_a !== 8'h99 || out_d !== 8'hC1) begin fails++; $display("FAIL other_data: got %h/%h exp 99/c1", out_a, out_d); end
      out_ready = 4'b1000;
      tick();
      tests++; if (out_d !== 8'hC2) begin fails++; $display("FAIL other_d_order: got %h exp c2", out_d); end
      out_ready = 4'hF;
      repeat (2) tick();
      out_ready = 4'h0;
      tests++; if (out_valid !== 4'b0000) begin fails++; $display("FAIL other_drain: got %b exp 0000", out_valid); end
   endtask

   task automatic test_async_reset();
      in_sel = 2'b01; in_valid = 1'b1; in_data = 8'hB1;
      tick();
      in_data = 8'hB2;
      tick();
      tests++; if (out_valid !== 4'b0010) begin fails++; $display("FAIL arst_pre: got %b exp 0010", out_valid); end
      in_sel = 2'b10;
      #1 rst = 1'b1;
      #1;
      tests++; if (out_valid !== 4'b0000 || out_b !== 8'h00) begin fails++; $display("FAIL arst_clear: got %b/%h exp 0000/00", out_valid, out_b); end
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL arst_ready: got %b exp 0", in_ready); end
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL arst_release: got %b exp 1", in_ready); end
      tick();
      tests++; if (out_valid !== 4'b0000) begin fails++; $display("FAIL arst_nothing: got %b exp 0000", out_valid); end
   endtask

   task automatic test_random();
      logic [7:0] mq [4][$];
      logic [7:0] last [4];
      int         bad = 0;
      for (int i = 0; i < 4; i++) last[i] = outs[i];
      for (int cyc = 0; cyc < 10000; cyc++) begin
         in_sel    = 2'($urandom_range(0, 3));
         in_data   = 8'($urandom);
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = 4'($urandom) & 4'($urandom);
         #1;
         tests++;
         if (in_ready !== (mq[in_sel].size() < 2)) begin
            fails++; bad++;
            if (bad < 10) $display("FAIL rand_in_ready cyc%0d: got %b exp %b", cyc, in_ready, mq[in_sel].size() < 2);
         end
         for (int i = 0; i < 4; i++) begin
            tests++;
            if (out_valid[i] !== (mq[i].size() > 0) || outs[i] !== (mq[i].size() > 0 ? mq[i][0] : last[i])) begin
               fails++; bad++;
               if (bad < 10) $display("FAIL rand_chan%0d cyc%0d: got %b/%h exp %b/%h", i, cyc, out_valid[i], outs[i],
                                      mq[i].size() > 0, mq[i].size() > 0 ? mq[i][0] : last[i]);
            end
         end
         tests++;
         if (busy !== (mq[0].size() + mq[1].size() + mq[2].size() + mq[3].size() > 0)) begin
            fails++; bad++;
            if (bad < 10) $display("FAIL rand_busy cyc%0d: got %b", cyc, busy);
         end
         // Reference: accept decided on pre-edge occupancy, then consume, then append.
         begin
            bit acc;
            acc = in_valid && (mq[in_sel].size() < 2);
            for (int i = 0; i < 4; i++)
               if (out_ready[i] && mq[i].size() > 0) void'(mq[i].pop_front());
            if (acc) mq[in_sel].push_back(in_data);
            for (int i = 0; i < 4; i++)
               if (mq[i].size() > 0) last[i] = mq[i][0];
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0; out_ready = 4'hF;
      repeat (3) tick();
      out_ready = 4'h0;
      tests++; if (out_valid !== 4'b0000) begin fails++; $display("FAIL rand_drain: got %b exp 0000", out_valid); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_simul();
      test_full_other();
      test_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
